// File: rtl/stash_scan_table_pkg.sv
// Shared constants for the stash scan/eviction scheduler: FSM state
// encodings and the width derivations used by every file of the block.
package stash_scan_table_pkg;

    typedef enum logic [1:0] {
        StateIdle  = 2'd0,
        StateScan  = 2'd1,
        StateHold  = 2'd2,
        StateDrain = 2'd3
    } scanState_t;

    // Bits needed to name a tree level 0..oramL.
    function automatic int levelWidth(input int oramL);
        return $clog2(oramL + 1);
    endfunction

    // Bits needed to hold a per-level fill count 0..oramZ.
    function automatic int slotWidth(input int oramZ);
        return $clog2(oramZ + 1);
    endfunction

    // Bits needed for a stash entry ID.
    function automatic int eidWidth(input int stashCapacity);
        return (stashCapacity > 1) ? $clog2(stashCapacity) : 1;
    endfunction

endpackage

// File: rtl/stash_scan_table_if.sv
// Entry-in / slot-out streams between the stash and the scan scheduler.
// master = stash/writeback side, slave = the scheduler.
interface stash_scan_table_if
    import stash_scan_table_pkg::*;
#(
    parameter int ORAML    = 32,
    parameter int EIDWidth = eidWidth(64)
);
    logic [EIDWidth-1:0] InEntry;
    logic [ORAML-1:0]    InLeaf;
    logic                InValid;
    logic                InLast;
    logic                InReady;

    logic [EIDWidth-1:0] OutEntry;
    logic                OutIsDummy;
    logic                OutValid;
    logic                OutReady;

    modport master (
        output InEntry, InLeaf, InValid, InLast, OutReady,
        input  InReady, OutEntry, OutIsDummy, OutValid
    );

    modport slave (
        input  InEntry, InLeaf, InValid, InLast, OutReady,
        output InReady, OutEntry, OutIsDummy, OutValid
    );
endinterface

// File: rtl/stash_scan_table_leaf_common_depth.sv
// Depth at which two root-to-leaf paths diverge: the count of leading
// (MSB-first) equal bits of the two leaves, 0..ORAML.
module leaf_common_depth
    import stash_scan_table_pkg::*;
#(
    parameter  int ORAML  = 32,
    localparam int LevelW = levelWidth(ORAML)
) (
    input  logic [ORAML-1:0]  LeafA,
    input  logic [ORAML-1:0]  LeafB,
    output logic [LevelW-1:0] Depth
);

    logic [ORAML-1:0] diff;

    assign diff = LeafA ^ LeafB;

    // Leading-zero count of the difference; the highest set bit wins.
    always_comb begin
        Depth = LevelW'(ORAML);
        for (int i = 0; i < ORAML; i++) begin
            if (diff[i]) begin
                Depth = LevelW'(ORAML - 1 - i);
            end
        end
    end

endmodule

// File: rtl/stash_scan_table.sv
// Stash scan/eviction scheduler: greedily places each scanned stash entry
// into the deepest free slot on the access path, then streams the
// (ORAML+1) x ORAMZ writeback table root-first with valid/ready handshake.
module stash_scan_table
    import stash_scan_table_pkg::*;
#(
    parameter  int ORAML         = 32,
    parameter  int ORAMZ         = 4,
    parameter  int StashCapacity = 64,
    localparam int EIDWidth      = eidWidth(StashCapacity)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [ORAML-1:0]    AccessLeaf,
    input  logic                StartScan,
    input  logic                StartWriteback,
    output logic                ScanDone,
    output logic                WritebackDone,
    output logic [EIDWidth:0]   NumPlaced,
    output logic [EIDWidth:0]   NumRejected,
    output logic                Busy,
    stash_scan_table_if.slave   bus
);

    localparam int LevelW = levelWidth(ORAML);
    localparam int SlotW  = slotWidth(ORAMZ);
    localparam int CountW = EIDWidth + 1;

    scanState_t          state;
    logic [ORAML-1:0]    accessLeafQ;
    logic [SlotW-1:0]    levelCount [ORAML+1];
    logic [EIDWidth-1:0] slotTable  [ORAML+1][ORAMZ];
    logic [LevelW-1:0]   drainLevel;
    logic [SlotW-1:0]    drainSlot;
    logic                inReadyQ;
    logic                outValidQ;
    logic                scanDoneQ;
    logic                writebackDoneQ;
    logic                busyQ;
    logic [CountW-1:0]   numPlacedQ;
    logic [CountW-1:0]   numRejectedQ;

    logic [LevelW-1:0]   entryDepth;
    logic                accept;
    logic                placeFound;
    logic [LevelW-1:0]   placeLevel;
    logic [EIDWidth-1:0] curEntry;
    logic [SlotW-1:0]    curCount;
    logic                curDummy;

    // Per-level fill count, held at ORAMZ once the bucket is full.
    function automatic logic [SlotW-1:0] bumpCount(input logic [SlotW-1:0] c);
        return (c < SlotW'(ORAMZ)) ? c + 1'b1 : c;
    endfunction

    // Placed/rejected tallies, held at all-ones rather than wrapping.
    function automatic logic [CountW-1:0] bumpTally(input logic [CountW-1:0] t);
        return (&t) ? t : t + 1'b1;
    endfunction

    leaf_common_depth #(.ORAML(ORAML)) depthCalc (
        .LeafA (bus.InLeaf),
        .LeafB (accessLeafQ),
        .Depth (entryDepth)
    );

    // InReady is high for the whole Scan state, so a valid entry is taken.
    assign accept = (state == StateScan) && bus.InValid;

    // Deepest level on the shared path prefix that still has a free slot.
    always_comb begin
        placeFound = 1'b0;
        placeLevel = '0;
        for (int k = 0; k <= ORAML; k++) begin
            if ((LevelW'(k) <= entryDepth) && (levelCount[k] < SlotW'(ORAMZ))) begin
                placeFound = 1'b1;
                placeLevel = LevelW'(k);
            end
        end
    end

    // Scheduler FSM with its counters and registered handshake/status flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= StateIdle;
            drainLevel     <= '0;
            drainSlot      <= '0;
            inReadyQ       <= 1'b0;
            outValidQ      <= 1'b0;
            scanDoneQ      <= 1'b0;
            writebackDoneQ <= 1'b0;
            busyQ          <= 1'b0;
            numPlacedQ     <= '0;
            numRejectedQ   <= '0;
            for (int l = 0; l <= ORAML; l++) begin
                levelCount[l] <= '0;
            end
        end else begin
            scanDoneQ      <= 1'b0;
            writebackDoneQ <= 1'b0;
            unique case (state)
                StateIdle: begin
                    if (StartScan) begin
                        state        <= StateScan;
                        inReadyQ     <= 1'b1;
                        busyQ        <= 1'b1;
                        numPlacedQ   <= '0;
                        numRejectedQ <= '0;
                        for (int l = 0; l <= ORAML; l++) begin
                            levelCount[l] <= '0;
                        end
                    end
                end
                StateScan: begin
                    if (accept) begin
                        if (placeFound) begin
                            levelCount[placeLevel] <= bumpCount(levelCount[placeLevel]);
                            numPlacedQ             <= bumpTally(numPlacedQ);
                        end else begin
                            numRejectedQ <= bumpTally(numRejectedQ);
                        end
                    end
                    // An early writeback wins over InLast; either way the
                    // entry handshaken this cycle is already counted above.
                    if (StartWriteback) begin
                        state      <= StateDrain;
                        inReadyQ   <= 1'b0;
                        outValidQ  <= 1'b1;
                        scanDoneQ  <= 1'b1;
                        drainLevel <= '0;
                        drainSlot  <= '0;
                    end else if (accept && bus.InLast) begin
                        state     <= StateHold;
                        inReadyQ  <= 1'b0;
                        scanDoneQ <= 1'b1;
                    end
                end
                StateHold: begin
                    if (StartWriteback) begin
                        state      <= StateDrain;
                        outValidQ  <= 1'b1;
                        drainLevel <= '0;
                        drainSlot  <= '0;
                    end
                end
                StateDrain: begin
                    if (bus.OutReady) begin
                        if (drainSlot == SlotW'(ORAMZ - 1)) begin
                            drainSlot <= '0;
                            if (drainLevel == LevelW'(ORAML)) begin
                                state          <= StateIdle;
                                outValidQ      <= 1'b0;
                                busyQ          <= 1'b0;
                                writebackDoneQ <= 1'b1;
                                drainLevel     <= '0;
                            end else begin
                                drainLevel <= drainLevel + 1'b1;
                            end
                        end else begin
                            drainSlot <= drainSlot + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Access leaf latch and slot table writes; pure data, no reset needed
    // because unfilled slots are masked by the level counts on readout.
    always_ff @(posedge Clock) begin
        if ((state == StateIdle) && StartScan) begin
            accessLeafQ <= AccessLeaf;
        end
        if (accept && placeFound) begin
            for (int l = 0; l <= ORAML; l++) begin
                for (int s = 0; s < ORAMZ; s++) begin
                    if ((placeLevel == LevelW'(l)) && (levelCount[l] == SlotW'(s))) begin
                        slotTable[l][s] <= bus.InEntry;
                    end
                end
            end
        end
    end

    // Select the table entry addressed by the drain pointer.
    always_comb begin
        curEntry = '0;
        for (int l = 0; l <= ORAML; l++) begin
            for (int s = 0; s < ORAMZ; s++) begin
                if ((drainLevel == LevelW'(l)) && (drainSlot == SlotW'(s))) begin
                    curEntry = slotTable[l][s];
                end
            end
        end
    end

    assign curCount = levelCount[drainLevel];
    assign curDummy = (drainSlot >= curCount);

    assign bus.InReady    = inReadyQ;
    assign bus.OutValid   = outValidQ;
    assign bus.OutIsDummy = outValidQ & curDummy;
    assign bus.OutEntry   = (outValidQ & ~curDummy) ? curEntry : '0;

    assign ScanDone      = scanDoneQ;
    assign WritebackDone = writebackDoneQ;
    assign NumPlaced     = numPlacedQ;
    assign NumRejected   = numRejectedQ;
    assign Busy          = busyQ;

endmodule

// File: tb/tb_stash_scan_table.sv
// Bench for stash_scan_table at ORAML=4, ORAMZ=2, StashCapacity=16:
// table-driven reference scenarios, corner sequences and a random sweep
// against a greedy placement model.
module tb_stash_scan_table;

    localparam int L    = 4;
    localparam int Z    = 2;
    localparam int CAP  = 16;
    localparam int EIDW = 4;
    localparam int NOUT = (L + 1) * Z;
    localparam logic [4:0] DUM = 5'h10;   // {isDummy, entry} of an empty slot

    logic           Clock = 1'b0;
    logic           Reset;
    logic [L-1:0]   AccessLeaf;
    logic           StartScan;
    logic           StartWriteback;
    logic           ScanDone;
    logic           WritebackDone;
    logic [EIDW:0]  NumPlaced;
    logic [EIDW:0]  NumRejected;
    logic           Busy;

    stash_scan_table_if #(.ORAML(L), .EIDWidth(EIDW)) bus ();

    stash_scan_table #(.ORAML(L), .ORAMZ(Z), .StashCapacity(CAP)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .AccessLeaf     (AccessLeaf),
        .StartScan      (StartScan),
        .StartWriteback (StartWriteback),
        .ScanDone       (ScanDone),
        .WritebackDone  (WritebackDone),
        .NumPlaced      (NumPlaced),
        .NumRejected    (NumRejected),
        .Busy           (Busy),
        .bus            (bus)
    );

    always #5 Clock = ~Clock;

    // Packed arrays: element 0 is the rightmost field of each literal.
    typedef struct packed {
        logic [3:0]            acc;
        logic [2:0]            n;
        logic [3:0][3:0]       eid;
        logic [3:0][3:0]       leaf;
        logic [NOUT-1:0][4:0]  expOut;
        logic [4:0]            placed;
        logic [4:0]            rejected;
    } vec_t;

    vec_t       vecs [3];
    int         nChecks = 0;
    int         nFail   = 0;
    logic [3:0] qEid [$];
    logic [3:0] qLeaf [$];
    logic [4:0] expOut [$];
    logic [4:0] got [$];
    int         expPlaced;
    int         expRejected;
    int         drainCycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    // Greedy placement straight from the rules: depth = shared prefix
    // length, then the deepest non-full bucket at or above that depth.
    task automatic buildModel(input logic [3:0] acc);
        int         cnt [L+1];
        logic [4:0] tab [L+1][Z];
        int         d;
        bit         placed;
        expOut.delete();
        expPlaced   = 0;
        expRejected = 0;
        for (int l = 0; l <= L; l++) cnt[l] = 0;
        for (int e = 0; e < qEid.size(); e++) begin
            d = 0;
            while (d < L && acc[L-1-d] == qLeaf[e][L-1-d]) d++;
            placed = 0;
            for (int k = d; k >= 0 && !placed; k--) begin
                if (cnt[k] < Z) begin
                    tab[k][cnt[k]] = {1'b0, qEid[e]};
                    cnt[k]++;
                    placed = 1;
                end
            end
            if (placed) expPlaced++;
            else        expRejected++;
        end
        for (int l = 0; l <= L; l++)
            for (int s = 0; s < Z; s++)
                expOut.push_back((s < cnt[l]) ? tab[l][s] : DUM);
    endtask

    // Starts a scan, feeds the queued entries and ends either with InLast
    // (then one Hold cycle and a StartWriteback) or with an early
    // StartWriteback alongside the final entry. Returns in the first
    // Drain cycle. glitch pulses StartScan with a foreign leaf mid-scan.
    task automatic runScan(input logic [3:0] acc, input bit early, input bit glitch);
        int n;
        n = qEid.size();
        AccessLeaf = acc;
        StartScan  = 1'b1;
        step();
        StartScan  = 1'b0;
        AccessLeaf = ~acc;
        check("scanInReady", bus.InReady, 1);
        check("scanBusy", Busy, 1);
        for (int i = 0; i < n; i++) begin
            bus.InValid    = 1'b1;
            bus.InEntry    = qEid[i];
            bus.InLeaf     = qLeaf[i];
            bus.InLast     = !early && (i == n - 1);
            StartWriteback = early && (i == n - 1);
            StartScan      = glitch && (i == 1);
            step();
            if (i != n - 1) check($sformatf("inReady%0d", i), bus.InReady, 1);
        end
        if (n == 0) begin
            StartWriteback = 1'b1;
            step();
        end
        bus.InValid    = 1'b0;
        bus.InLast     = 1'b0;
        StartScan      = 1'b0;
        StartWriteback = 1'b0;
        check("scanDone", ScanDone, 1);
        check("inReadyOff", bus.InReady, 0);
        check("outValidAtScanEnd", bus.OutValid, early);
        if (!early) begin
            step();
            check("holdScanDoneLow", ScanDone, 0);
            check("holdOutValid", bus.OutValid, 0);
            check("holdBusy", Busy, 1);
            StartWriteback = 1'b1;
            step();
            StartWriteback = 1'b0;
            check("drainScanDoneLow", ScanDone, 0);
        end
    endtask

    // Collects handshaken slots until WritebackDone. readyMode:
    // 0 = always ready, 1 = toggle starting low, 2 = random.
    task automatic drainTable(input int readyMode);
        bit         prevStall;
        logic [4:0] prevCode;
        logic [4:0] code;
        int         i;
        got.delete();
        drainCycles = 0;
        prevStall   = 0;
        prevCode    = '0;
        for (i = 0; i < 200; i++) begin
            if (WritebackDone) break;
            code = {bus.OutIsDummy, bus.OutEntry};
            if (bus.OutValid) begin
                drainCycles++;
                if (prevStall) check("stallHold", code, prevCode);
                case (readyMode)
                    0:       bus.OutReady = 1'b1;
                    1:       bus.OutReady = (drainCycles % 2 == 0);
                    default: bus.OutReady = ($urandom_range(0, 1) == 1);
                endcase
                if (bus.OutReady) got.push_back(code);
                prevStall = !bus.OutReady;
                prevCode  = code;
            end else begin
                bus.OutReady = 1'b0;
            end
            step();
        end
        bus.OutReady = 1'b0;
        if (i == 200) begin
            nChecks++;
            nFail++;
            $display("FAIL drainTimeout: got no WritebackDone, expected it within 200 cycles");
        end
        check("wbIdleBusy", Busy, 0);
        check("wbOutValid", bus.OutValid, 0);
    endtask

    task automatic compareOut(input string tag);
        check({tag, ".count"}, got.size(), expOut.size());
        for (int i = 0; i < expOut.size() && i < got.size(); i++)
            check($sformatf("%s.slot%0d", tag, i), got[i], expOut[i]);
    endtask

    task automatic runCase(input string tag, input logic [3:0] acc, input bit early,
                           input int readyMode, input bit glitch);
        runScan(acc, early, glitch);
        check({tag, ".placed"}, NumPlaced, expPlaced);
        check({tag, ".rejected"}, NumRejected, expRejected);
        drainTable(readyMode);
        compareOut(tag);
        if (readyMode == 0) check({tag, ".cycles"}, drainCycles, NOUT);
        if (readyMode == 1) check({tag, ".cycles"}, drainCycles, 2 * NOUT);
        check({tag, ".placedHeld"}, NumPlaced, expPlaced);
    endtask

    task automatic loadVec(input int v);
        qEid.delete();
        qLeaf.delete();
        expOut.delete();
        for (int i = 0; i < vecs[v].n; i++) begin
            qEid.push_back(vecs[v].eid[i]);
            qLeaf.push_back(vecs[v].leaf[i]);
        end
        for (int i = 0; i < NOUT; i++) expOut.push_back(vecs[v].expOut[i]);
        expPlaced   = vecs[v].placed;
        expRejected = vecs[v].rejected;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] acc;
        int         n;
        bit         early;

        // Expected slot order: index 0 (rightmost) is level 0 slot 0.
        vecs[0] = '{acc: 4'hF, n: 3'd4, eid: {4'd3, 4'd2, 4'd1, 4'd0},
                    leaf: {4'hF, 4'hF, 4'hF, 4'hF},
                    expOut: {5'd1, 5'd0, 5'd3, 5'd2, DUM, DUM, DUM, DUM, DUM, DUM},
                    placed: 5'd4, rejected: 5'd0};
        vecs[1] = '{acc: 4'hF, n: 3'd3, eid: {4'd0, 4'd7, 4'd6, 4'd5},
                    leaf: {4'h0, 4'h0, 4'h0, 4'h0},
                    expOut: {DUM, DUM, DUM, DUM, DUM, DUM, DUM, DUM, 5'd6, 5'd5},
                    placed: 5'd2, rejected: 5'd1};
        vecs[2] = '{acc: 4'hA, n: 3'd3, eid: {4'd0, 4'd3, 4'd2, 4'd1},
                    leaf: {4'h0, 4'h0, 4'h8, 4'hB},
                    expOut: {DUM, DUM, DUM, 5'd1, DUM, 5'd2, DUM, DUM, DUM, 5'd3},
                    placed: 5'd3, rejected: 5'd0};

        Reset          = 1'b1;
        AccessLeaf     = '0;
        StartScan      = 1'b0;
        StartWriteback = 1'b0;
        bus.InEntry    = '0;
        bus.InLeaf     = '0;
        bus.InValid    = 1'b0;
        bus.InLast     = 1'b0;
        bus.OutReady   = 1'b0;
        repeat (3) step();
        check("rstInReady", bus.InReady, 0);
        check("rstOutValid", bus.OutValid, 0);
        check("rstOutIsDummy", bus.OutIsDummy, 0);
        check("rstOutEntry", bus.OutEntry, 0);
        check("rstScanDone", ScanDone, 0);
        check("rstWbDone", WritebackDone, 0);
        check("rstBusy", Busy, 0);
        check("rstPlaced", NumPlaced, 0);
        check("rstRejected", NumRejected, 0);
        Reset = 1'b0;

        // Idle ignores StartWriteback and InValid.
        StartWriteback = 1'b1;
        bus.InValid    = 1'b1;
        step();
        StartWriteback = 1'b0;
        bus.InValid    = 1'b0;
        check("idleIgnoreBusy", Busy, 0);
        check("idleIgnoreOutValid", bus.OutValid, 0);

        // Reference scenarios: full match, root overflow, mixed depth.
        for (int v = 0; v < 3; v++) begin
            loadVec(v);
            runCase($sformatf("vec%0d", v), vecs[v].acc, 1'b0, 0, 1'b0);
        end

        // Empty stash: scan ended by StartWriteback alone.
        qEid.delete();
        qLeaf.delete();
        expOut.delete();
        for (int i = 0; i < NOUT; i++) expOut.push_back(DUM);
        expPlaced   = 0;
        expRejected = 0;
        runCase("empty", 4'h5, 1'b1, 0, 1'b0);

        // Backpressure: full-match table with OutReady toggling.
        loadVec(0);
        runCase("bp", vecs[0].acc, 1'b0, 1, 1'b0);

        // StartScan mid-scan with another leaf must change nothing.
        loadVec(0);
        runScan(vecs[0].acc, 1'b0, 1'b1);
        check("glitch.placed", NumPlaced, 4);
        check("glitch.rejected", NumRejected, 0);

        // Reset three slots into the drain aborts with no done pulse.
        bus.OutReady = 1'b1;
        repeat (3) step();
        bus.OutReady = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("midRstBusy", Busy, 0);
        check("midRstOutValid", bus.OutValid, 0);
        check("midRstOutEntry", bus.OutEntry, 0);
        check("midRstOutIsDummy", bus.OutIsDummy, 0);
        check("midRstWbDone", WritebackDone, 0);
        check("midRstPlaced", NumPlaced, 0);
        step();
        check("midRstWbDoneLater", WritebackDone, 0);
        check("midRstStillIdle", Busy, 0);
        loadVec(2);
        runCase("afterRst", vecs[2].acc, 1'b0, 0, 1'b0);

        // Random sweep against the model, back-to-back accesses.
        for (int t = 0; t < 30; t++) begin
            acc = 4'($urandom_range(0, 15));
            n   = $urandom_range(0, 8);
            qEid.delete();
            qLeaf.delete();
            for (int i = 0; i < n; i++) begin
                qEid.push_back(4'($urandom_range(0, 15)));
                if ($urandom_range(0, 3) == 0) qLeaf.push_back(acc);
                else                           qLeaf.push_back(4'($urandom_range(0, 15)));
            end
            early = (n == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            buildModel(acc);
            runCase($sformatf("rnd%0d", t), acc, early, $urandom_range(0, 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
